// File: rtl/sdsu_bus_pkg.sv
// Shared definitions for the SDSU bus responder: default widths, wait-counter
// width and the FSM state encoding.
package sdsu_bus_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/sdsu_bus_regfile.sv
// Register file for the SDSU bus responder: 2**ADDR_W x DATA_W, one synchronous
// write port, one asynchronous read port, synchronous active-low clear.
// Optional feature: define SDSU_BUS_ZERO_REG_EN to hard-wire register 0 to zero.
module sdsu_bus_regfile import sdsu_bus_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

`ifdef SDSU_BUS_ZERO_REG_EN
    // Register 0 never stores anything, so writes to it are dropped and reads see zero.
    assign wr_en = we && (wa != '0);
    assign rd    = (ra == '0) ? '0 : mem_q[ra];
`else
    assign wr_en = we;
    assign rd    = mem_q[ra];
`endif

    // Clear every register on reset, otherwise perform the single write of the cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa] <= wd;
        end
    end

endmodule

// File: rtl/sdsu_bus_slave.sv
// SDSU bus responder: latches a request on the strobe, waits WAIT_CYCLES states,
// then commits one write and one (write-first) read and holds ready until the
// strobe drops. Optional feature: SDSU_BUS_ZERO_REG_EN makes register 0 read as
// zero with no forwarding of a simultaneous write to address 0.
module sdsu_bus_slave import sdsu_bus_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              signal,
    input  logic [ADDR_W-1:0] w_adr,
    input  logic [ADDR_W-1:0] r_adr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              ready
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [ADDR_W-1:0]  w_adr_q,  w_adr_d;
    logic [ADDR_W-1:0]  r_adr_q,  r_adr_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic [DATA_W-1:0]  r_data_q, r_data_d;
    logic               ready_q,  ready_d;
    logic               commit;
    logic [DATA_W-1:0]  rf_rd;
    logic [DATA_W-1:0]  rd_fwd;

    sdsu_bus_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .wa    (w_adr_q),
        .wd    (w_data_q),
        .ra    (r_adr_q),
        .rd    (rf_rd)
    );

`ifdef SDSU_BUS_ZERO_REG_EN
    assign rd_fwd = (r_adr_q == '0)      ? '0       :
                    (r_adr_q == w_adr_q) ? w_data_q : rf_rd;
`else
    assign rd_fwd = (r_adr_q == w_adr_q) ? w_data_q : rf_rd;
`endif

    // Next-state logic: capture in IDLE, count wait states, commit, then hold until strobe drops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_adr_d  = w_adr_q;
        r_adr_d  = r_adr_q;
        w_data_d = w_data_q;
        r_data_d = r_data_q;
        ready_d  = ready_q;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (signal) begin
                    w_adr_d  = w_adr;
                    r_adr_d  = r_adr;
                    w_data_d = w_data;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!signal) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_CNT) begin
                    commit   = 1'b1;
                    r_data_d = rd_fwd;
                    ready_d  = 1'b1;
                    state_d  = S_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (!signal) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            w_adr_q  <= '0;
            r_adr_q  <= '0;
            w_data_q <= '0;
            r_data_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_adr_q  <= w_adr_d;
            r_adr_q  <= r_adr_d;
            w_data_q <= w_data_d;
            r_data_q <= r_data_d;
            ready_q  <= ready_d;
        end
    end

    assign r_data = r_data_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_sdsu_bus_slave.sv
// Directed bench for sdsu_bus_slave: one instance with two wait states and one
// with none. Expected register contents in the SDSU_BUS_ZERO_REG_EN build differ
// only for address 0.
module tb_sdsu_bus_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signal;
    logic [4:0]  w_adr;
    logic [4:0]  r_adr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        ready;

    logic        sig0;
    logic [4:0]  w_adr0;
    logic [4:0]  r_adr0;
    logic [31:0] w_data0;
    logic [31:0] r_data0;
    logic        ready0;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] hold_rd;
    logic [31:0] zero_exp;

    sdsu_bus_slave #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .signal (signal),
        .w_adr  (w_adr),
        .r_adr  (r_adr),
        .w_data (w_data),
        .r_data (r_data),
        .ready  (ready)
    );

    sdsu_bus_slave #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .signal (sig0),
        .w_adr  (w_adr0),
        .r_adr  (r_adr0),
        .w_data (w_data0),
        .r_data (r_data0),
        .ready  (ready0)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [4:0] wa, input logic [4:0] ra,
                                 input logic [31:0] wd);
        signal = s;
        w_adr  = wa;
        r_adr  = ra;
        w_data = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs_rd, input logic obs_rdy,
                               input logic [31:0] exp_rd, input logic exp_rdy);
        vectors++;
        assert (obs_rdy === exp_rdy) else begin
            miscompares++;
            $error("[TB] FAIL %s ready observed=%b expected=%b", tag, obs_rdy, exp_rdy);
        end
        vectors++;
        assert (obs_rd === exp_rd) else begin
            miscompares++;
            $error("[TB] FAIL %s r_data observed=%h expected=%h", tag, obs_rd, exp_rd);
        end
    endtask

    // Full transaction on the two-wait-state instance, with input churn after capture.
    task automatic doTxn(input string tag, input logic [4:0] wa, input logic [4:0] ra,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
        applyStimulus(1'b1, wa, ra, wd);
        tick();
        checkOutput({tag, "_cap"}, r_data, ready, hold_rd, 1'b0);
        applyStimulus(1'b1, ~wa, wa, ~wd);
        tick();
        checkOutput({tag, "_w1"}, r_data, ready, hold_rd, 1'b0);
        tick();
        checkOutput({tag, "_w2"}, r_data, ready, hold_rd, 1'b0);
        tick();
        hold_rd = exp_rd;
        checkOutput({tag, "_ack"}, r_data, ready, hold_rd, 1'b1);
        applyStimulus(1'b0, wa, ra, wd);
        tick();
        checkOutput({tag, "_drop"}, r_data, ready, hold_rd, 1'b0);
    endtask

    initial begin
        hold_rd = 32'h0;
`ifdef SDSU_BUS_ZERO_REG_EN
        zero_exp = 32'h0;
`else
        zero_exp = 32'h1;
`endif
        sig0 = 1'b0; w_adr0 = '0; r_adr0 = '0; w_data0 = '0;

        // 1: reset held for two edges with a request pending
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd3, 32'h55);
        sig0 = 1'b1;
        tick();
        tick();
        checkOutput("rst", r_data, ready, 32'h0, 1'b0);
        checkOutput("rst_w0", r_data0, ready0, 32'h0, 1'b0);
        applyStimulus(1'b0, 5'd3, 5'd3, 32'h55);
        sig0 = 1'b0;
        rst_n = 1'b1;
        tick();
        checkOutput("rst_rel", r_data, ready, 32'h0, 1'b0);
        doTxn("rst_rd3", 5'd30, 5'd3, 32'h1, 32'h0);

        // 2: basic write then read back
        doTxn("wr1", 5'd1, 5'd16, 32'h7, 32'h0);
        doTxn("rd1", 5'd2, 5'd1, 32'h3, 32'h7);

        // 3: write-first forwarding, including the top address
        doTxn("wf5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        doTxn("wf31", 5'd31, 5'd31, 32'h31, 32'h31);

        // 4: one-cycle strobe aborts in WAIT
        applyStimulus(1'b1, 5'd4, 5'd2, 32'h9);
        tick();
        applyStimulus(1'b0, 5'd4, 5'd2, 32'h9);
        tick();
        checkOutput("abort_a", r_data, ready, hold_rd, 1'b0);
        tick();
        tick();
        checkOutput("abort_b", r_data, ready, hold_rd, 1'b0);
        doTxn("abort_rd4", 5'd6, 5'd4, 32'h66, 32'h0);

        // 5: strobe held in ACK while inputs churn
        applyStimulus(1'b1, 5'd7, 5'd2, 32'h11);
        tick();
        tick();
        tick();
        tick();
        hold_rd = 32'h3;
        checkOutput("held_ack", r_data, ready, hold_rd, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'(8 + i), 5'(8 + i), 32'hF0 + 32'(i));
            tick();
            checkOutput("held_churn", r_data, ready, hold_rd, 1'b1);
        end
        applyStimulus(1'b0, 5'd7, 5'd2, 32'h11);
        tick();
        checkOutput("held_drop", r_data, ready, hold_rd, 1'b0);
        doTxn("held_rd7", 5'd13, 5'd7, 32'h99, 32'h11);
        doTxn("held_rd8", 5'd14, 5'd8, 32'h98, 32'h0);
        doTxn("held_rd12", 5'd15, 5'd12, 32'h97, 32'h0);
        doTxn("rd5", 5'd16, 5'd5, 32'h96, 32'hDEADBEEF);

        // Reset lands on the commit edge of an in-flight request
        applyStimulus(1'b1, 5'd21, 5'd5, 32'h77);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        hold_rd = 32'h0;
        checkOutput("rst_mid", r_data, ready, hold_rd, 1'b0);
        applyStimulus(1'b0, 5'd21, 5'd5, 32'h77);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_mid_rel", r_data, ready, hold_rd, 1'b0);
        doTxn("rst_mid_rd21", 5'd22, 5'd21, 32'h5, 32'h0);

        // 6: register 0 behaviour (build-dependent)
        doTxn("zero_wf", 5'd0, 5'd0, 32'h1, zero_exp);
        doTxn("zero_rd", 5'd23, 5'd0, 32'h2, zero_exp);

        // 6b: zero wait states on the second instance
        sig0 = 1'b1; w_adr0 = 5'd3; r_adr0 = 5'd3; w_data0 = 32'h55;
        tick();
        checkOutput("w0_cap", r_data0, ready0, 32'h0, 1'b0);
        w_adr0 = 5'd9; w_data0 = 32'hAA;
        tick();
        checkOutput("w0_ack", r_data0, ready0, 32'h55, 1'b1);
        sig0 = 1'b0;
        tick();
        checkOutput("w0_drop", r_data0, ready0, 32'h55, 1'b0);
        sig0 = 1'b1; w_adr0 = 5'd4; r_adr0 = 5'd9; w_data0 = 32'h1;
        tick();
        tick();
        checkOutput("w0_rd9", r_data0, ready0, 32'h0, 1'b1);
        sig0 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
